// File: rtl/snake_move_ctrl.sv
// rtl/snake_move_ctrl.sv - snake head movement controller with border collision and start/restart
module snake_move_ctrl #(
   parameter int HOR_PIX         = 1024,
   parameter int VER_PIX         = 768,
   parameter int GRID_SIZE       = 16,
   parameter int FRAME_X_SIZE    = 40,
   parameter int FRAME_Y_SIZE    = 20,
   parameter int FRAMES_PER_STEP = 8
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vsync_in,
   input  logic [1:0]  dir_in,
   input  logic        dir_valid,
   input  logic        start,
   output logic [10:0] head_x,
   output logic [10:0] head_y,
   output logic [5:0]  head_col,
   output logic [4:0]  head_row,
   output logic        move_tick,
   output logic        game_over,
   output logic        running
);

   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

   localparam int X_OFF = (HOR_PIX - FRAME_X_SIZE * GRID_SIZE) / 2;
   localparam int Y_OFF = (VER_PIX - FRAME_Y_SIZE * GRID_SIZE) / 2;
   localparam int CW    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   localparam logic [5:0]    COL0     = 6'(FRAME_X_SIZE / 2);
   localparam logic [4:0]    ROW0     = 5'(FRAME_Y_SIZE / 2);
   localparam logic [5:0]    COL_LAST = 6'(FRAME_X_SIZE - 1);
   localparam logic [4:0]    ROW_LAST = 5'(FRAME_Y_SIZE - 1);
   localparam logic [10:0]   X0       = 11'(X_OFF + (FRAME_X_SIZE / 2) * GRID_SIZE);
   localparam logic [10:0]   Y0       = 11'(Y_OFF + (FRAME_Y_SIZE / 2) * GRID_SIZE);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   state_t        state_q, state_d;
   logic          vsync_q;
   logic [CW-1:0] frame_cnt, frame_cnt_d;
   logic [1:0]    cur_dir, cur_dir_d;
   logic [1:0]    pending_dir, pending_dir_d;
   logic [5:0]    col_d, next_col;
   logic [4:0]    row_d, next_row;
   logic [10:0]   x_d, y_d;
   logic          tick_d;
   logic          frame_tick, step, hit, dir_accept;
   logic [1:0]    dir_ref;

   // Frame tick, step qualification, candidate next cell and border test
   always_comb begin
      frame_tick = vsync_in & ~vsync_q;
      step       = (state_q == RUN) && frame_tick && (frame_cnt == CNT_LAST);
      next_col   = head_col;
      next_row   = head_row;
      case (pending_dir)
         DIR_UP:    next_row = head_row - 5'd1;
         DIR_RIGHT: next_col = head_col + 6'd1;
         DIR_DOWN:  next_row = head_row + 5'd1;
         DIR_LEFT:  next_col = head_col - 6'd1;
         default:   next_col = head_col;
      endcase
      hit = (next_col == 6'd0) || (next_col == COL_LAST) ||
            (next_row == 5'd0) || (next_row == ROW_LAST);
      // A request arriving with a step is judged against the direction that step commits
      dir_ref    = step ? pending_dir : cur_dir;
      dir_accept = dir_valid && (state_q != OVER) && (dir_in != (dir_ref ^ 2'b10));
   end

   // Next-state and datapath update for IDLE / RUN / OVER
   always_comb begin
      state_d       = state_q;
      frame_cnt_d   = frame_cnt;
      cur_dir_d     = cur_dir;
      pending_dir_d = dir_accept ? dir_in : pending_dir;
      col_d         = head_col;
      row_d         = head_row;
      x_d           = head_x;
      y_d           = head_y;
      tick_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               frame_cnt_d = '0;
            end
         end
         RUN: begin
            if (frame_tick) begin
               frame_cnt_d = step ? '0 : frame_cnt + 1'b1;
            end
            if (step) begin
               cur_dir_d = pending_dir;
               if (hit) begin
                  state_d = OVER;
               end else begin
                  col_d  = next_col;
                  row_d  = next_row;
                  x_d    = 11'(X_OFF) + 11'(next_col) * 11'(GRID_SIZE);
                  y_d    = 11'(Y_OFF) + 11'(next_row) * 11'(GRID_SIZE);
                  tick_d = 1'b1;
               end
            end
         end
         OVER: begin
            if (start) begin
               state_d       = IDLE;
               frame_cnt_d   = '0;
               cur_dir_d     = DIR_RIGHT;
               pending_dir_d = DIR_RIGHT;
               col_d         = COL0;
               row_d         = ROW0;
               x_d           = X0;
               y_d           = Y0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset returns everything to the centre, heading right
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         vsync_q     <= 1'b0;
         frame_cnt   <= '0;
         cur_dir     <= DIR_RIGHT;
         pending_dir <= DIR_RIGHT;
         head_col    <= COL0;
         head_row    <= ROW0;
         head_x      <= X0;
         head_y      <= Y0;
         move_tick   <= 1'b0;
      end else begin
         state_q     <= state_d;
         vsync_q     <= vsync_in;
         frame_cnt   <= frame_cnt_d;
         cur_dir     <= cur_dir_d;
         pending_dir <= pending_dir_d;
         head_col    <= col_d;
         head_row    <= row_d;
         head_x      <= x_d;
         head_y      <= y_d;
         move_tick   <= tick_d;
      end
   end

   assign running   = (state_q == RUN);
   assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb/tb_snake_move_ctrl.sv - directed self-checking bench for snake_move_ctrl
module tb_snake_move_ctrl;

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic        vsync_in = 1'b0;
   logic [1:0]  dir_in = 2'b00;
   logic        dir_valid = 1'b0;
   logic        start = 1'b0;
   logic [10:0] head_x, head_y;
   logic [5:0]  head_col;
   logic [4:0]  head_row;
   logic        move_tick, game_over, running;

   int checks = 0;
   int passed = 0;
   int mt_cnt = 0;

   snake_move_ctrl dut (
      .pclk      (pclk),
      .rst       (rst),
      .vsync_in  (vsync_in),
      .dir_in    (dir_in),
      .dir_valid (dir_valid),
      .start     (start),
      .head_x    (head_x),
      .head_y    (head_y),
      .head_col  (head_col),
      .head_row  (head_row),
      .move_tick (move_tick),
      .game_over (game_over),
      .running   (running)
   );

   always #5 pclk = ~pclk;

   // Count move_tick pulses, sampled away from the active edge
   always @(negedge pclk) if (move_tick === 1'b1) mt_cnt++;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
      else passed++;
   endtask

   task automatic do_reset();
      rst = 1'b1; vsync_in = 1'b0; dir_valid = 1'b0; start = 1'b0; dir_in = 2'b00;
      repeat (2) @(negedge pclk);
      rst = 1'b0;
      @(negedge pclk);
   endtask

   task automatic pulse_start();
      @(negedge pclk) start = 1'b1;
      @(negedge pclk) start = 1'b0;
   endtask

   // One video frame; optional direction request coincident with the vsync rising edge
   task automatic frame(input bit dv, input logic [1:0] d);
      @(negedge pclk) begin vsync_in = 1'b1; dir_valid = dv; dir_in = d; end
      @(negedge pclk) dir_valid = 1'b0;
      @(negedge pclk) vsync_in = 1'b0;
      repeat (3) @(negedge pclk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame(1'b0, 2'b00);
   endtask

   task automatic req_dir(input logic [1:0] d);
      @(negedge pclk) begin dir_valid = 1'b1; dir_in = d; end
      @(negedge pclk) dir_valid = 1'b0;
   endtask

   task automatic test_reset();
      int m0;
      do_reset();
      chk("reset_head_x", head_x, 512);
      chk("reset_head_y", head_y, 384);
      chk("reset_col", head_col, 20);
      chk("reset_row", head_row, 10);
      m0 = mt_cnt;
      frames(3);
      chk("idle_head_x", head_x, 512);
      chk("idle_head_y", head_y, 384);
      chk("idle_running", running, 0);
      chk("idle_game_over", game_over, 0);
      chk("idle_no_move", mt_cnt - m0, 0);
   endtask

   task automatic test_first_step();
      int m0;
      do_reset();
      pulse_start();
      chk("start_running", running, 1);
      m0 = mt_cnt;
      frames(3);
      pulse_start();
      chk("start_in_run_ignored", running, 1);
      frames(4);
      chk("no_move_after_7", mt_cnt - m0, 0);
      frames(1);
      chk("one_move_after_8", mt_cnt - m0, 1);
      chk("step_col", head_col, 21);
      chk("step_x", head_x, 528);
      chk("step_y", head_y, 384);
   endtask

   task automatic test_reversal();
      do_reset();
      pulse_start();
      req_dir(2'b11);
      frames(8);
      chk("reversal_col", head_col, 21);
      chk("reversal_row", head_row, 10);
      req_dir(2'b00);
      frames(8);
      chk("up_row", head_row, 9);
      chk("up_y", head_y, 368);
      chk("up_col", head_col, 21);
   endtask

   task automatic test_back_to_back();
      int m0;
      do_reset();
      pulse_start();
      m0 = mt_cnt;
      frames(7);
      frame(1'b1, 2'b00);
      chk("same_cycle_col", head_col, 21);
      chk("same_cycle_row", head_row, 10);
      frames(8);
      chk("latched_row", head_row, 9);
      chk("latched_col", head_col, 21);
      chk("latched_moves", mt_cnt - m0, 2);
   endtask

   task automatic test_border();
      int m0;
      do_reset();
      pulse_start();
      frames(17 * 8);
      chk("run17_col", head_col, 37);
      chk("run17_x", head_x, 784);
      frames(8);
      chk("run18_col", head_col, 38);
      chk("run18_running", running, 1);
      m0 = mt_cnt;
      frames(8);
      chk("hit_game_over", game_over, 1);
      chk("hit_running", running, 0);
      chk("hit_col_held", head_col, 38);
      chk("hit_x_held", head_x, 800);
      chk("hit_no_move", mt_cnt - m0, 0);
   endtask

   task automatic test_over_restart();
      req_dir(2'b00);
      frames(8);
      chk("over_frozen_col", head_col, 38);
      pulse_start();
      chk("restart_game_over", game_over, 0);
      chk("restart_running", running, 0);
      chk("restart_col", head_col, 20);
      chk("restart_row", head_row, 10);
      chk("restart_x", head_x, 512);
      pulse_start();
      chk("restart_run", running, 1);
      frames(8);
      chk("restart_dir_col", head_col, 21);
      chk("restart_dir_row", head_row, 10);
   endtask

   task automatic test_async_reset();
      do_reset();
      pulse_start();
      frames(40);
      frames(3);
      chk("pre_rst_col", head_col, 25);
      chk("pre_rst_x", head_x, 592);
      chk("pre_rst_cnt", int'(dut.frame_cnt), 3);
      @(negedge pclk);
      #2 rst = 1'b1;
      #1;
      chk("arst_col", head_col, 20);
      chk("arst_row", head_row, 10);
      chk("arst_x", head_x, 512);
      chk("arst_y", head_y, 384);
      chk("arst_running", running, 0);
      chk("arst_move_tick", move_tick, 0);
      chk("arst_cnt", int'(dut.frame_cnt), 0);
      @(negedge pclk) rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_step();
      test_reversal();
      test_back_to_back();
      test_border();
      test_over_restart();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/snake_move_ctrl.md
Name: snake_move_ctrl

Overview:
- Movement controller for the snake head.
- Sits directly upstream of the snake draw stage and supplies its head_x / head_y pixel coordinates.
- Advances the head one grid cell every FRAMES_PER_STEP video frames, in the direction last requested by the keyboard decoder.
- Detects collision with the frame border, ends the game, and supports start/restart.

Parameters:
- HOR_PIX, 1024, horizontal active pixels
- VER_PIX, 768, vertical active pixels
- GRID_SIZE, 16, cell size in pixels
- FRAME_X_SIZE, 40, playfield width in cells, border included
- FRAME_Y_SIZE, 20, playfield height in cells, border included
- FRAMES_PER_STEP, 8, frames per one-cell move (>=1)

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset: asynchronous, active-high
- vsync_in  in  1  vsync from timing chain; rising edge = frame tick
- dir_in  in  2  requested direction: 00 up, 01 right, 10 down, 11 left
- dir_valid  in  1  one-cycle strobe qualifying dir_in
- start  in  1  one-cycle strobe: start game / restart after game over
- head_x  out  11  head top-left pixel x
- head_y  out  11  head top-left pixel y
- head_col  out  6  head cell column, 0..FRAME_X_SIZE-1
- head_row  out  5  head cell row, 0..FRAME_Y_SIZE-1
- move_tick  out  1  one-cycle pulse on each executed move
- game_over  out  1  high while in OVER
- running  out  1  high while in RUN

Behaviour:
- Reset is asynchronous, active-high; clock is pclk. Reset values:
  - state = IDLE
  - head_col = FRAME_X_SIZE/2 (20), head_row = FRAME_Y_SIZE/2 (10)
  - cur_dir = pending_dir = 01 (right)
  - frame counter = 0
  - move_tick = 0, game_over = 0, running = 0
  - head_x = 512, head_y = 384
- Derived constants:
  - X_OFF = (HOR_PIX - FRAME_X_SIZE*GRID_SIZE)/2 = 192
  - Y_OFF = (VER_PIX - FRAME_Y_SIZE*GRID_SIZE)/2 = 224
- Pixel outputs:
  - head_x = X_OFF + head_col*GRID_SIZE; head_y = Y_OFF + head_row*GRID_SIZE.
  - Both are registered and updated in the same cycle as head_col/head_row, with no extra latency.
- Frame tick: vsync_in is registered once. frame_tick = vsync_in & ~vsync_q (one cycle).
- Frame counter: runs only in RUN; incremented on frame_tick. When the count equals FRAMES_PER_STEP-1 and frame_tick is high, step is asserted and the counter returns to 0.
- Direction capture:
  - Applies in IDLE and RUN only; dir_valid is ignored in OVER.
  - On dir_valid, pending_dir <= dir_in, unless dir_in == cur_dir ^ 2'b10 (reversal). Reversals are ignored.
  - Last valid request before a step wins.
- Step:
  - cur_dir <= pending_dir.
  - Next cell is computed from pending_dir: up row-1, right col+1, down row+1, left col-1.
- Collision:
  - If the next cell has col == 0, col == FRAME_X_SIZE-1, row == 0 or row == FRAME_Y_SIZE-1 (border), the state goes to OVER.
  - Head position holds on collision and move_tick stays 0.
  - Otherwise the head moves and move_tick = 1 for one cycle, the cycle after step.
- Simultaneous events:
  - dir_valid in the same cycle as step does not affect that step; it is latched for the next one.
  - start in RUN is ignored.
- FSM:
  - IDLE: position and direction held at reset values. start -> RUN, frame counter cleared.
  - RUN: running = 1. Steps as above. Border hit -> OVER.
  - OVER: game_over = 1, position frozen. start -> IDLE with position, cur_dir, pending_dir and counter restored to reset values.
- Wrap-around: none; border cells are terminal. Coordinate arithmetic never underflows, because the head never occupies a border cell.
- Reset mid-operation: immediate return to reset values regardless of state; any in-flight step is discarded.

Test Plan:
- Reset, then 3 vsync pulses with no start -> head_x=512, head_y=384, running=0, no move_tick.
- start, then 8 vsync rising edges, no dir -> exactly one move_tick; head_col=21, head_x=528, head_y=384.
- In RUN heading right, dir_valid with dir_in=11 (left), then step -> reversal ignored; head_col increments to 21. Then dir_in=00, next step -> head_row=9, head_y=368.
- Run right from col 20 for 17 steps -> col=37, x=784. 18th step (next col 38 is interior) -> col=38. 19th step targets col 39 -> game_over=1, running=0, head_col stays 38, no move_tick.
- In OVER, dir_valid then start -> state IDLE, head_col=20, head_row=10, cur_dir=01. A second start -> RUN.
- rst asserted asynchronously mid-frame in RUN at col 25 -> outputs at reset values before the next pclk edge; frame counter = 0.
